// File: rtl/benes32_frame_loader_if.sv
// ---------------------------------------------------------------------------
// benes32_frame_loader_if
// Bundle for the Benes-32 frame loader: the serial word stream coming in, the
// lane-parallel frame going out, and the framing-error pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface benes32_frame_loader_if #(
  parameter int N     = 32,
  parameter int LANES = 32,
  parameter int B32   = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         in_data;
  logic                 in_last;
  logic [B32-1:0]       in_cfg;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   out_lanes;
  logic [B32-1:0]       out_cfg;
  logic                 frame_err;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, in_data, in_last, in_cfg, out_ready,
    input  in_ready, out_valid, out_lanes, out_cfg, frame_err
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, in_last, in_cfg, out_ready,
    output in_ready, out_valid, out_lanes, out_cfg, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/benes32_frame_loader.sv
// ---------------------------------------------------------------------------
// benes32_frame_loader
// Double-banked input stage for the 32-lane Benes network. Serial words are
// gathered into one bank while the other bank is held on the lane-parallel
// output for the network. Malformed frames are dropped with a one-cycle
// frame_err pulse.
// Optional build macro: BENES32_LOADER_BITREV_EN -- when defined, word index
// i is stored in lane bitrev5(i) instead of lane i.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module benes32_frame_loader #(
  parameter int N     = 32,
  parameter int LANES = 32,
  parameter int B32   = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  benes32_frame_loader_if.slave   bus
);

  logic [N-1:0]       lane_mem [2][LANES];
  logic [B32-1:0]     cfg_mem  [2];
  logic [1:0]         full;
  logic               wb;
  logic               rb;
  logic [4:0]         wptr;
  logic               err_pulse;

  logic [4:0]         wlane;
  logic               accept;
  logic               drain;
  logic               ptr_end;
  logic [LANES*N-1:0] lanes_flat;

  // Destination lane for the current word index
  always_comb begin
    wlane = wptr;
`ifdef BENES32_LOADER_BITREV_EN
    wlane = {wptr[0], wptr[1], wptr[2], wptr[3], wptr[4]};
`endif
  end

  // in_ready comes only from the full flag of the write bank, never from
  // in_valid or out_ready.
  assign accept  = bus.in_valid && !full[wb];
  assign drain   = full[rb] && bus.out_ready;
  assign ptr_end = (wptr == 5'd31);

  // Bank fill, framing check and drain bookkeeping. A fill and a drain in the
  // same cycle always touch different banks: the fill bank is empty and the
  // drain bank is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        cfg_mem[b] <= '0;
        for (int k = 0; k < LANES; k++) begin
          lane_mem[b][k] <= '0;
        end
      end
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wptr      <= 5'd0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (accept) begin
        lane_mem[wb][wlane] <= bus.in_data;
        if (wptr == 5'd0) begin
          cfg_mem[wb] <= bus.in_cfg;
        end
        if (ptr_end && bus.in_last) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wptr     <= 5'd0;
        end else if (ptr_end || bus.in_last) begin
          // Frame length mismatch: restart in the same bank, old words are
          // simply overwritten by the next frame.
          wptr      <= 5'd0;
          err_pulse <= 1'b1;
        end else begin
          wptr <= wptr + 5'd1;
        end
      end
      if (drain) begin
        full[rb] <= 1'b0;
        rb       <= ~rb;
      end
    end
  end

  // Present the read bank as a flat lane-parallel bus, lane 0 in the LSBs
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lanes_flat[k*N +: N] = lane_mem[rb][k];
  end

  assign bus.in_ready  = !full[wb];
  assign bus.out_valid = full[rb];
  assign bus.out_lanes = lanes_flat;
  assign bus.out_cfg   = cfg_mem[rb];
  assign bus.frame_err = err_pulse;

endmodule

`default_nettype wire

// File: tb/tb_benes32_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_benes32_frame_loader
// Directed bench for the Benes-32 frame loader: single frame, backpressure,
// framing errors, overlapped streaming and mid-frame reset.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_benes32_frame_loader;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  benes32_frame_loader_if #(.N(32), .LANES(32), .B32(9)) bus ();

  benes32_frame_loader #(.N(32), .LANES(32), .B32(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          stalls  = 0;
  int          hs_cnt  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] exp_base [4];
  logic [8:0]  exp_cfg  [4];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Word index that lands in lane k
  function automatic logic [4:0] word_of_lane(input int k);
    logic [4:0] v;
    v = k[4:0];
`ifdef BENES32_LOADER_BITREV_EN
    return {v[0], v[1], v[2], v[3], v[4]};
`else
    return v;
`endif
  endfunction

  task automatic check_frame(input string tag, input logic [31:0] base, input logic [8:0] cfg);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_cfg"}, 64'(bus.out_cfg), 64'(cfg));
    for (int k = 0; k < 32; k++) begin
      check($sformatf("%s_lane%0d", tag, k), 64'(bus.out_lanes[k*32 +: 32]),
            64'(base + 32'(word_of_lane(k))));
    end
  endtask

  // Drive nbeats words base+i; in_last on beat last_at (-1: never)
  task automatic send_frame(input logic [31:0] base, input logic [8:0] cfg,
                            input int nbeats, input int last_at);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = base + 32'(i);
      bus.in_last  = (i == last_at);
      bus.in_cfg   = (i == 0) ? cfg : 9'h0FF;
      if (!bus.in_ready) begin
        int g;
        stalls++;
        g = 0;
        while (!bus.in_ready && g < 100) begin
          @(negedge clk);
          g++;
        end
        if (!bus.in_ready) begin
          check("stall_timeout", 64'd0, 64'd1);
          return;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain_one();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // Handshake monitor for the overlapped-stream section
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (hs_cnt < 4) begin
        check($sformatf("ovl_cfg%0d", hs_cnt), 64'(bus.out_cfg), 64'(exp_cfg[hs_cnt]));
        check($sformatf("ovl_l5_%0d", hs_cnt), 64'(bus.out_lanes[5*32 +: 32]),
              64'(exp_base[hs_cnt] + 32'(word_of_lane(5))));
        check($sformatf("ovl_l31_%0d", hs_cnt), 64'(bus.out_lanes[31*32 +: 32]),
              64'(exp_base[hs_cnt] + 32'd31));
      end
      hs_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_cfg    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_lanes_any", 64'(|bus.out_lanes), 64'd0);
    check("rst_cfg", 64'(bus.out_cfg), 64'd0);
    check("rst_err", 64'(bus.frame_err), 64'd0);
    rst_n = 1'b1;

    // Single frame
    send_frame(32'h100, 9'h1A5, 32, 31);
    check("single_pre_valid", 64'(bus.out_valid), 64'd0);
    idle();
    check_frame("single", 32'h100, 9'h1A5);
`ifdef BENES32_LOADER_BITREV_EN
    check("single_lane16", 64'(bus.out_lanes[16*32 +: 32]), 64'h101);
    check("single_lane24", 64'(bus.out_lanes[24*32 +: 32]), 64'h103);
`else
    check("single_lane16", 64'(bus.out_lanes[16*32 +: 32]), 64'h110);
`endif
    check("single_in_ready", 64'(bus.in_ready), 64'd1);
    check("single_err", 64'(bus.frame_err), 64'd0);
    drain_one();
    check("single_drained", 64'(bus.out_valid), 64'd0);

    // Backpressure: two frames fill both banks, third is held off
    stalls = 0;
    send_frame(32'h200, 9'h011, 32, 31);
    send_frame(32'h300, 9'h022, 32, 31);
    check("bp_stalls_ab", 64'(stalls), 64'd0);
    idle();
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    check_frame("bp_a", 32'h200, 9'h011);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h400;
    bus.in_cfg   = 9'h033;
    repeat (3) @(negedge clk);
    check("bp_ready_still_low", 64'(bus.in_ready), 64'd0);
    check_frame("bp_a_hold", 32'h200, 9'h011);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
    check_frame("bp_b", 32'h300, 9'h022);
    send_frame(32'h400, 9'h033, 32, 31);
    idle();
    check("bp_ready_low2", 64'(bus.in_ready), 64'd0);
    check_frame("bp_b_hold", 32'h300, 9'h022);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_frame("bp_c", 32'h400, 9'h033);
    drain_one();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Framing error: early in_last
    send_frame(32'h500, 9'h044, 11, 10);
    idle();
    check("err_early_pulse", 64'(bus.frame_err), 64'd1);
    check("err_early_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("err_early_once", 64'(bus.frame_err), 64'd0);
    send_frame(32'h600, 9'h0AA, 32, 31);
    idle();
    check("err_early_next_err", 64'(bus.frame_err), 64'd0);
    check_frame("err_early_next", 32'h600, 9'h0AA);
    drain_one();

    // Framing error: 32 beats without in_last
    send_frame(32'h700, 9'h055, 32, -1);
    idle();
    check("err_nolast_pulse", 64'(bus.frame_err), 64'd1);
    check("err_nolast_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("err_nolast_once", 64'(bus.frame_err), 64'd0);
    send_frame(32'h800, 9'h066, 32, 31);
    idle();
    check_frame("err_nolast_next", 32'h800, 9'h066);
    drain_one();

    // Overlapped streaming with out_ready held high
    for (int f = 0; f < 4; f++) begin
      exp_base[f] = 32'hC00 + 32'(f) * 32'h100;
      exp_cfg[f]  = 9'h0A0 + 9'(f);
    end
    stalls        = 0;
    hs_cnt        = 0;
    bus.out_ready = 1'b1;
    mon_en        = 1'b1;
    for (int f = 0; f < 4; f++) begin
      send_frame(exp_base[f], exp_cfg[f], 32, 31);
    end
    idle();
    repeat (4) @(negedge clk);
    mon_en        = 1'b0;
    bus.out_ready = 1'b0;
    check("ovl_stalls", 64'(stalls), 64'd0);
    check("ovl_handshakes", 64'(hs_cnt), 64'd4);
    check("ovl_empty", 64'(bus.out_valid), 64'd0);

    // Reset mid-frame with one bank full
    send_frame(32'h900, 9'h077, 32, 31);
    send_frame(32'hA00, 9'h088, 20, -1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    @(negedge clk);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_lanes_any", 64'(|bus.out_lanes), 64'd0);
    check("mrst_cfg", 64'(bus.out_cfg), 64'd0);
    check("mrst_err", 64'(bus.frame_err), 64'd0);
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    send_frame(32'hB00, 9'h155, 32, 31);
    idle();
    check("mrst_lane0", 64'(bus.out_lanes[31:0]), 64'hB00);
    check_frame("mrst_next", 32'hB00, 9'h155);
    check("mrst_next_err", 64'(bus.frame_err), 64'd0);
    drain_one();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/benes32_frame_loader.md
# benes32_frame_loader

Input stage for the 32-lane Beneš permutation network. It collects a serial stream of N-bit words, one per accepted beat, into a complete 32-lane frame together with its 9-bit switch setting. It presents each finished frame as a lane-parallel bus that feeds the network's 32 data inputs and its switch-control input. Two frame banks let loading of frame k+1 overlap with the downstream network holding frame k.

## Interface
Parameters:
- N, 32, lane word width.
- LANES, 32, lanes per frame; fixed at 32 (the pointer is 5 bits).
- B32, 9, switch-control width.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  N  lane word.
- in_last  in  1  marks the final (32nd) word of a frame.
- in_cfg  in  B32  switch setting; sampled only on the word at index 0.
- out_valid  out  1  a complete frame is presented.
- out_ready  in  1  downstream consumes the frame.
- out_lanes  out  LANES*N  lane k is at bits [k*N +: N]; lane 0 drives the network's first input.
- out_cfg  out  B32  switch setting of the presented frame.
- frame_err  out  1  one-cycle pulse when a frame is dropped for a framing error.

## Operation
- State: two banks (0 and 1), each holding 32×N data, a B32 cfg field and a full flag; write-bank select wb; read-bank select rb; 5-bit word index wptr.
- in_ready = !full[wb]. A beat is accepted when in_valid && in_ready.
- On an accepted beat, in_data is written to lane wptr of bank wb. If wptr==0, in_cfg is also written to cfg[wb].
- Framing rules on an accepted beat:
  - wptr==31 with in_last=1: set full[wb]; toggle wb; wptr←0.
  - wptr==31 with in_last=0: discard the frame; wptr←0; frame_err pulses; wb is unchanged; full is unchanged.
  - wptr<31 with in_last=1: same discard behaviour as the previous case.
  - Otherwise: wptr←wptr+1.
- Output side:
  - out_valid = full[rb]; out_lanes and out_cfg come from bank rb.
  - When out_valid && out_ready: clear full[rb] and toggle rb.
  - While out_valid && !out_ready, out_lanes and out_cfg are held stable.
- Fill and drain in the same cycle act on different banks, so both proceed. When both banks are full, in_ready=0 until a drain occurs.
- Discarded lane contents are not cleared. They are overwritten by the next frame.

## Timing
- Reset (rst_n=0 at a rising edge): wptr=0, wb=0, rb=0, both full flags=0, bank data and cfg=0. After reset: in_ready=1, out_valid=0, out_lanes=0, out_cfg=0, frame_err=0.
- A rst_n assertion mid-frame drops any partial frame and any full banks. No frame_err is raised.
- Latency: if the last word is accepted at edge T, out_valid=1 after edge T. The frame is visible in the same cycle the flags update.
- in_ready depends only on registered state. There is no combinational path from in_valid to in_ready, or from out_ready to in_ready.
- The drain that frees a bank at edge T raises in_ready after edge T.
- Sustained throughput is one frame per 32 cycles with out_ready held at 1.
- frame_err is registered: high for exactly the cycle following the offending beat.

## Configuration
- BENES32_LOADER_BITREV_EN defined: word index i is written to lane bitrev5(i). Example: index 1 goes to lane 16 and index 3 goes to lane 24. This gives a bit-reversed lane order for FFT-style permutations.
- Not defined: word index i is written to lane i.
- Framing, handshake and cfg capture are identical in both builds.

## Test plan
- Single frame: after reset, send words 0x100+i for i=0..31 with in_last on i=31 and in_cfg=0x1A5 on i=0. Required: out_valid rises the cycle after the last beat; lane k = 0x100+k; out_cfg = 0x1A5. Without the macro, lane 16 = 0x110.
- Backpressure: hold out_ready=0 and stream three frames back to back. Required: frames 1 and 2 are accepted, in_ready drops after the 64th beat, and out_lanes stays stable. Raising out_ready for 1 cycle presents frame 2 and restores in_ready the next cycle.
- Framing errors:
  - in_last on beat 10: frame_err pulses once, no out_valid, and the next 32-beat frame is delivered correctly.
  - Beat 31 without in_last: same result.
- Overlap: out_ready=1 while streaming 4 frames with no gaps. Required: in_ready is never low, exactly 4 out_valid handshakes occur, and cfg values match per frame.
- Reset mid-frame: reset after 20 beats with bank 0 full. Required: out_valid=0 and out_lanes=0 after the reset edge, frame_err=0, and the next frame lands in bank 0 at lane 0.
- Macro build: with BENES32_LOADER_BITREV_EN defined, word i=1 appears at lane 16 and i=31 appears at lane 31.
